// File: rtl/uivtc_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : uivtc_prog_if
// Description : Configuration bus for the programmable video timing
//               controller. Carries a complete timing set plus an update
//               strobe toward the controller, and the reject/pending status
//               back from it.
//   master : drives cfg_*_i and cfg_upd_i; observes cfg_err_o, cfg_pend_o
//   slave  : the timing controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface uivtc_prog_if #(
    parameter int CNT_W = 12
) ();
    logic [CNT_W-1:0] cfg_h_act_i;
    logic [CNT_W-1:0] cfg_h_tot_i;
    logic [CNT_W-1:0] cfg_hs_start_i;
    logic [CNT_W-1:0] cfg_hs_end_i;
    logic [CNT_W-1:0] cfg_v_act_i;
    logic [CNT_W-1:0] cfg_v_tot_i;
    logic [CNT_W-1:0] cfg_vs_start_i;
    logic [CNT_W-1:0] cfg_vs_end_i;
    logic             cfg_hs_pol_i;
    logic             cfg_vs_pol_i;
    logic             cfg_upd_i;
    logic             cfg_err_o;
    logic             cfg_pend_o;

    modport master (
        output cfg_h_act_i, cfg_h_tot_i, cfg_hs_start_i, cfg_hs_end_i,
        output cfg_v_act_i, cfg_v_tot_i, cfg_vs_start_i, cfg_vs_end_i,
        output cfg_hs_pol_i, cfg_vs_pol_i, cfg_upd_i,
        input  cfg_err_o, cfg_pend_o
    );

    modport slave (
        input  cfg_h_act_i, cfg_h_tot_i, cfg_hs_start_i, cfg_hs_end_i,
        input  cfg_v_act_i, cfg_v_tot_i, cfg_vs_start_i, cfg_vs_end_i,
        input  cfg_hs_pol_i, cfg_vs_pol_i, cfg_upd_i,
        output cfg_err_o, cfg_pend_o
    );
endinterface
`default_nettype wire

// File: rtl/uivtc_prog.sv
`default_nettype none
// ============================================================================
// Module      : uivtc_prog
// Description : Runtime-programmable video timing controller. Generates
//               HS/VS/DE, an early pixel request, pixel coordinates, a
//               frame-start pulse and a completed-frame counter. New timing
//               is validated on cfg_upd_i and only takes effect on a frame
//               boundary (or at once while idle).
// Ports       :
//   vtc_clk_i / vtc_rstn_i : pixel clock, async active-low reset
//   vtc_en_i               : run enable (level); a frame always completes
//   cfg (slave)            : timing set, update strobe, err/pending status
//   vtc_hs_o/vs_o/de_o     : video syncs (polarity applied) and data enable
//   vtc_req_o              : DE predicted REQ_LEAD cycles early
//   vtc_x_o / vtc_y_o      : coordinates aligned with vtc_de_o, else 0
//   vtc_fs_o               : pulse with pixel (0,0) on vtc_de_o
//   vtc_frame_cnt_o        : completed frames, wraps at 16 bits
// Revision    : 1.0 - initial release
// ============================================================================
module uivtc_prog #(
    parameter int CNT_W        = 12,
    parameter int REQ_LEAD     = 1,
    parameter int DEF_H_ACT    = 1920,
    parameter int DEF_H_TOT    = 2200,
    parameter int DEF_HS_START = 2008,
    parameter int DEF_HS_END   = 2052,
    parameter int DEF_V_ACT    = 1080,
    parameter int DEF_V_TOT    = 1125,
    parameter int DEF_VS_START = 1084,
    parameter int DEF_VS_END   = 1089,
    parameter bit DEF_HS_POL   = 1'b1,
    parameter bit DEF_VS_POL   = 1'b1
) (
    input  logic             vtc_clk_i,
    input  logic             vtc_rstn_i,
    input  logic             vtc_en_i,
    uivtc_prog_if.slave      cfg,
    output logic             vtc_hs_o,
    output logic             vtc_vs_o,
    output logic             vtc_de_o,
    output logic             vtc_req_o,
    output logic [CNT_W-1:0] vtc_x_o,
    output logic [CNT_W-1:0] vtc_y_o,
    output logic             vtc_fs_o,
    output logic [15:0]      vtc_frame_cnt_o
);

    typedef struct packed {
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] h_tot;
        logic [CNT_W-1:0] hs_start;
        logic [CNT_W-1:0] hs_end;
        logic [CNT_W-1:0] v_act;
        logic [CNT_W-1:0] v_tot;
        logic [CNT_W-1:0] vs_start;
        logic [CNT_W-1:0] vs_end;
        logic             hs_pol;
        logic             vs_pol;
    } cfg_t;

    typedef struct packed {
        logic             de;
        logic             hs;
        logic             vs;
        logic             fs;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
    } pix_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_four = CNT_W'(4);

    localparam cfg_t c_def_cfg = '{
        h_act:    CNT_W'(DEF_H_ACT),
        h_tot:    CNT_W'(DEF_H_TOT),
        hs_start: CNT_W'(DEF_HS_START),
        hs_end:   CNT_W'(DEF_HS_END),
        v_act:    CNT_W'(DEF_V_ACT),
        v_tot:    CNT_W'(DEF_V_TOT),
        vs_start: CNT_W'(DEF_VS_START),
        vs_end:   CNT_W'(DEF_VS_END),
        hs_pol:   DEF_HS_POL,
        vs_pol:   DEF_VS_POL
    };

    localparam pix_t c_pix_rst = '{
        de: 1'b0, hs: ~DEF_HS_POL, vs: ~DEF_VS_POL, fs: 1'b0, x: '0, y: '0
    };

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hcnt, r_vcnt, w_hcnt_nxt, w_vcnt_nxt;
    cfg_t             r_act, r_pend_cfg, w_eff, w_new;
    logic             r_pend, r_err, r_req;
    logic [15:0]      r_frame_cnt;
    pix_t             r_pipe [0:REQ_LEAD];
    pix_t             w_pix;
    logic             w_run, w_fend, w_valid, w_apply;
    logic             w_de_raw, w_hs_raw, w_vs_raw;

    // A pending config is applied on the first idle cycle, so if enable rises
    // on that same cycle pixel (0,0) must already use the pending set.
    assign w_eff = (r_state == ST_IDLE && r_pend) ? r_pend_cfg : r_act;
    // The IDLE->RUN cycle is itself pixel (0,0).
    assign w_run = (r_state == ST_RUN) || vtc_en_i;

    always_comb begin
        w_new.h_act    = cfg.cfg_h_act_i;
        w_new.h_tot    = cfg.cfg_h_tot_i;
        w_new.hs_start = cfg.cfg_hs_start_i;
        w_new.hs_end   = cfg.cfg_hs_end_i;
        w_new.v_act    = cfg.cfg_v_act_i;
        w_new.v_tot    = cfg.cfg_v_tot_i;
        w_new.vs_start = cfg.cfg_vs_start_i;
        w_new.vs_end   = cfg.cfg_vs_end_i;
        w_new.hs_pol   = cfg.cfg_hs_pol_i;
        w_new.vs_pol   = cfg.cfg_vs_pol_i;
    end

    assign w_valid = (w_new.h_act != '0) && (w_new.h_act < w_new.hs_start) &&
                     (w_new.hs_start < w_new.hs_end) && (w_new.hs_end <= w_new.h_tot) &&
                     (w_new.v_act != '0) && (w_new.v_act <= w_new.vs_start) &&
                     (w_new.vs_start < w_new.vs_end) && (w_new.vs_end <= w_new.v_tot) &&
                     (w_new.h_tot >= c_four);

    // Next-state and counter advance
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_vcnt_nxt  = r_vcnt;
        w_fend      = 1'b0;
        if (w_run) begin
            if (r_hcnt == w_eff.h_tot - c_one) begin
                w_hcnt_nxt = '0;
                if (r_vcnt == w_eff.v_tot - c_one) begin
                    w_vcnt_nxt = '0;
                    w_fend     = 1'b1;
                end else begin
                    w_vcnt_nxt = r_vcnt + c_one;
                end
            end else begin
                w_hcnt_nxt = r_hcnt + c_one;
            end
            w_state_nxt = (w_fend && !vtc_en_i) ? ST_IDLE : ST_RUN;
        end
    end

    always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
        if (!vtc_rstn_i) begin
            r_state     <= ST_IDLE;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_vcnt  <= w_vcnt_nxt;
            if (w_fend) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Config staging. On a coincident update and apply, the old pending set
    // goes active (non-blocking read) while the new one becomes pending.
    assign w_apply = (r_state == ST_IDLE || w_fend) && r_pend;

    always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
        if (!vtc_rstn_i) begin
            r_act      <= c_def_cfg;
            r_pend_cfg <= c_def_cfg;
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= cfg.cfg_upd_i && !w_valid;
            if (w_apply) begin
                r_act <= r_pend_cfg;
            end
            if (cfg.cfg_upd_i && w_valid) begin
                r_pend_cfg <= w_new;
                r_pend     <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Raw timing from the counters; forced inactive while idle
    assign w_de_raw = w_run && (r_hcnt < w_eff.h_act) && (r_vcnt < w_eff.v_act);
    assign w_hs_raw = w_run && (r_hcnt >= w_eff.hs_start) && (r_hcnt < w_eff.hs_end);
    assign w_vs_raw = w_run && (r_vcnt >= w_eff.vs_start) && (r_vcnt < w_eff.vs_end);

    always_comb begin
        w_pix.de = w_de_raw;
        w_pix.hs = w_hs_raw ^ ~w_eff.hs_pol;
        w_pix.vs = w_vs_raw ^ ~w_eff.vs_pol;
        w_pix.fs = w_de_raw && (r_hcnt == '0) && (r_vcnt == '0);
        w_pix.x  = w_de_raw ? r_hcnt : '0;
        w_pix.y  = w_de_raw ? r_vcnt : '0;
    end

    // req sees raw DE after one stage; everything else after 1+REQ_LEAD
    always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
        if (!vtc_rstn_i) begin
            r_req <= 1'b0;
            for (int i = 0; i <= REQ_LEAD; i++) begin
                r_pipe[i] <= c_pix_rst;
            end
        end else begin
            r_req     <= w_de_raw;
            r_pipe[0] <= w_pix;
            for (int i = 1; i <= REQ_LEAD; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign vtc_req_o       = r_req;
    assign vtc_de_o        = r_pipe[REQ_LEAD].de;
    assign vtc_hs_o        = r_pipe[REQ_LEAD].hs;
    assign vtc_vs_o        = r_pipe[REQ_LEAD].vs;
    assign vtc_fs_o        = r_pipe[REQ_LEAD].fs;
    assign vtc_x_o         = r_pipe[REQ_LEAD].x;
    assign vtc_y_o         = r_pipe[REQ_LEAD].y;
    assign vtc_frame_cnt_o = r_frame_cnt;
    assign cfg.cfg_err_o   = r_err;
    assign cfg.cfg_pend_o  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_uivtc_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_uivtc_prog
// Description : Self-checking bench for uivtc_prog. A frame-position model
//               (pixel index within the frame, divided into line/column)
//               predicts every output each cycle; directed scenarios add
//               hand-computed expectations, followed by randomized updates
//               and enable toggling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uivtc_prog;
    localparam int CNT_W = 12;
    localparam int LEAD  = 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        hs, vs, de, req, fs;
    logic [11:0] x, y;
    logic [15:0] fcnt;

    uivtc_prog_if #(.CNT_W(CNT_W)) bus ();

    uivtc_prog #(.CNT_W(CNT_W), .REQ_LEAD(LEAD)) dut (
        .vtc_clk_i       (clk),
        .vtc_rstn_i      (rst_n),
        .vtc_en_i        (en),
        .cfg             (bus),
        .vtc_hs_o        (hs),
        .vtc_vs_o        (vs),
        .vtc_de_o        (de),
        .vtc_req_o       (req),
        .vtc_x_o         (x),
        .vtc_y_o         (y),
        .vtc_fs_o        (fs),
        .vtc_frame_cnt_o (fcnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: position p within the frame; line = p / h_tot,
    // column = p % h_tot. hist[k] is what the raw timing was k cycles ago.
    // ------------------------------------------------------------------
    typedef struct {
        int h_act, h_tot, hs_s, hs_e, v_act, v_tot, vs_s, vs_e;
        bit hp, vp;
    } mcfg_t;

    typedef struct {
        bit de, hs, vs, fs;
        int x, y;
    } rec_t;

    mcfg_t       m_act, m_pcfg, m_eff, m_new;
    bit          m_pend, m_run, m_err, m_fe, m_go;
    int          m_p, m_h, m_v;
    int unsigned m_fcnt;
    rec_t        hist [0:4];
    rec_t        m_r;

    function automatic mcfg_t def_cfg();
        mcfg_t c;
        c = '{1920, 2200, 2008, 2052, 1080, 1125, 1084, 1089, 1'b1, 1'b1};
        return c;
    endfunction

    function automatic bit cfg_ok(input mcfg_t c);
        return (c.h_act > 0) && (c.h_act < c.hs_s) && (c.hs_s < c.hs_e) && (c.hs_e <= c.h_tot) &&
               (c.v_act > 0) && (c.v_act <= c.vs_s) && (c.vs_s < c.vs_e) && (c.vs_e <= c.v_tot) &&
               (c.h_tot >= 4);
    endfunction

    function automatic rec_t idle_rec(input mcfg_t c);
        rec_t r;
        r = '{1'b0, !c.hp, !c.vp, 1'b0, 0, 0};
        return r;
    endfunction

    function automatic mcfg_t bus_cfg();
        mcfg_t c;
        c.h_act = int'(bus.cfg_h_act_i);   c.h_tot = int'(bus.cfg_h_tot_i);
        c.hs_s  = int'(bus.cfg_hs_start_i); c.hs_e = int'(bus.cfg_hs_end_i);
        c.v_act = int'(bus.cfg_v_act_i);   c.v_tot = int'(bus.cfg_v_tot_i);
        c.vs_s  = int'(bus.cfg_vs_start_i); c.vs_e = int'(bus.cfg_vs_end_i);
        c.hp    = bus.cfg_hs_pol_i;        c.vp    = bus.cfg_vs_pol_i;
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  = def_cfg();
            m_pcfg = def_cfg();
            m_pend = 1'b0;
            m_run  = 1'b0;
            m_err  = 1'b0;
            m_p    = 0;
            m_fcnt = 0;
            for (int k = 0; k < 5; k++) hist[k] = idle_rec(def_cfg());
        end else begin
            m_eff = (!m_run && m_pend) ? m_pcfg : m_act;
            m_go  = m_run || en;
            if (m_go) begin
                m_h    = m_p % m_eff.h_tot;
                m_v    = m_p / m_eff.h_tot;
                m_r.de = (m_h < m_eff.h_act) && (m_v < m_eff.v_act);
                m_r.hs = ((m_h >= m_eff.hs_s) && (m_h < m_eff.hs_e)) == m_eff.hp;
                m_r.vs = ((m_v >= m_eff.vs_s) && (m_v < m_eff.vs_e)) == m_eff.vp;
                m_r.fs = m_r.de && (m_p == 0);
                m_r.x  = m_r.de ? m_h : 0;
                m_r.y  = m_r.de ? m_v : 0;
            end else begin
                m_r = idle_rec(m_eff);
            end
            m_fe = m_go && (m_p == m_eff.h_tot * m_eff.v_tot - 1);
            for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = m_r;
            if ((!m_run || m_fe) && m_pend) begin
                m_act  = m_pcfg;
                m_pend = 1'b0;
            end
            m_err = 1'b0;
            if (bus.cfg_upd_i) begin
                m_new = bus_cfg();
                if (cfg_ok(m_new)) begin
                    m_pcfg = m_new;
                    m_pend = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_go) m_p = m_fe ? 0 : m_p + 1;
            m_run = m_go && !(m_fe && !en);
            if (m_fe) m_fcnt++;
        end
    end

    // Per-cycle comparison of every output against the model
    logic [46:0] cmp_a, cmp_e;
    always @(negedge clk) begin
        if (chk_on) begin
            cmp_a = {req, de, hs, vs, fs, bus.cfg_err_o, bus.cfg_pend_o, x, y, fcnt};
            cmp_e = {hist[0].de, hist[LEAD].de, hist[LEAD].hs, hist[LEAD].vs, hist[LEAD].fs,
                     m_err, m_pend, 12'(hist[LEAD].x), 12'(hist[LEAD].y), 16'(m_fcnt)};
            chk($sformatf("cycle t=%0t {req,de,hs,vs,fs,err,pend,x,y,fcnt}", $time),
                64'(cmp_a), 64'(cmp_e));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int ha, ht, hss, hse, va, vt, vss, vse, input bit hp, vp);
        bus.cfg_h_act_i = 12'(ha);  bus.cfg_h_tot_i = 12'(ht);
        bus.cfg_hs_start_i = 12'(hss); bus.cfg_hs_end_i = 12'(hse);
        bus.cfg_v_act_i = 12'(va);  bus.cfg_v_tot_i = 12'(vt);
        bus.cfg_vs_start_i = 12'(vss); bus.cfg_vs_end_i = 12'(vse);
        bus.cfg_hs_pol_i = hp;      bus.cfg_vs_pol_i = vp;
        bus.cfg_upd_i = 1'b1;
        @(negedge clk);
        bus.cfg_upd_i = 1'b0;
    endtask

    task automatic wait_fs(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (fs === 1'b1) ok = 1'b1;
        end
        chk("fs seen within bound", 64'(ok), 64'(1));
    endtask

    task automatic fs_gap(input string name, input int exp_n);
        int n = 0;
        bit ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (fs === 1'b1) ok = 1'b1;
        end
        chk(name, 64'(ok ? n : -1), 64'(exp_n));
    endtask

    // Called on an fs cycle; counts one 72-cycle small-timing frame
    task automatic measure_frame(input int exp_req, exp_de, exp_hs, exp_vs);
        int nde = 0, nhs = 0, nvs = 0, nreq = 0;
        logic [15:0] f0;
        f0 = fcnt;
        chk("x at frame start", 64'(x), 64'(0));
        chk("y at frame start", 64'(y), 64'(0));
        for (int i = 0; i < 72; i++) begin
            nde += int'(de); nhs += int'(hs); nvs += int'(vs); nreq += int'(req);
            @(negedge clk);
        end
        chk("fs period 72", 64'(fs), 64'(1));
        chk("frame_cnt +1 per frame", 64'(16'(fcnt - f0)), 64'(1));
        chk("req count per frame", 64'(nreq), 64'(exp_req));
        chk("de count per frame", 64'(nde), 64'(exp_de));
        chk("hs high count per frame", 64'(nhs), 64'(exp_hs));
        chk("vs high count per frame", 64'(nvs), 64'(exp_vs));
    endtask

    task automatic rand_cfg(input bit make_bad);
        int ha, hss, hse, ht, va, vss, vse, vt;
        ha  = int'($urandom_range(1, 6));
        hss = ha + 1 + int'($urandom_range(0, 2));
        hse = hss + 1 + int'($urandom_range(0, 2));
        ht  = hse + int'($urandom_range(0, 2));
        if (ht < 4) ht = 4;
        va  = int'($urandom_range(1, 4));
        vss = va + int'($urandom_range(0, 1));
        vse = vss + 1 + int'($urandom_range(0, 1));
        vt  = vse + int'($urandom_range(0, 2));
        if (make_bad) begin
            case ($urandom_range(0, 4))
                0: ha = 0;
                1: hse = hss;
                2: ht = hse - 1;
                3: va = vss + 1;
                default: begin ha = 1; hss = 2; hse = 3; ht = 3; end
            endcase
        end
        set_cfg(ha, ht, hss, hse, va, vt, vss, vse, 1'($urandom), 1'($urandom));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit found;
        int nde;
        logic [15:0] f0;
        bit prev_hs;

        bus.cfg_h_act_i = '0; bus.cfg_h_tot_i = '0; bus.cfg_hs_start_i = '0; bus.cfg_hs_end_i = '0;
        bus.cfg_v_act_i = '0; bus.cfg_v_tot_i = '0; bus.cfg_vs_start_i = '0; bus.cfg_vs_end_i = '0;
        bus.cfg_hs_pol_i = 1'b0; bus.cfg_vs_pol_i = 1'b0; bus.cfg_upd_i = 1'b0;

        // Reset state
        cyc(3);
        chk("reset de", 64'(de), 64'(0));
        chk("reset req", 64'(req), 64'(0));
        chk("reset hs inactive", 64'(hs), 64'(0));
        chk("reset vs inactive", 64'(vs), 64'(0));
        chk("reset frame_cnt", 64'(fcnt), 64'(0));
        chk("reset cfg_pend", 64'(bus.cfg_pend_o), 64'(0));
        rst_n  = 1'b1;
        chk_on = 1'b1;
        cyc(2);

        // Small timing loaded while idle: pending for one cycle, then applied
        set_cfg(8, 12, 9, 10, 4, 6, 4, 5, 1'b1, 1'b1);
        chk("pend after idle update", 64'(bus.cfg_pend_o), 64'(1));
        cyc(1);
        chk("pend cleared in idle", 64'(bus.cfg_pend_o), 64'(0));
        en = 1'b1;
        wait_fs(200);
        measure_frame(32, 32, 6, 12);
        measure_frame(32, 32, 6, 12);

        // HS polarity flip mid-frame takes effect at the next frame
        cyc(20);
        set_cfg(8, 12, 9, 10, 4, 6, 4, 5, 1'b0, 1'b1);
        wait_fs(200);
        measure_frame(32, 32, 66, 12);

        // Invalid config (h_act = h_tot = 12)
        set_cfg(12, 12, 9, 10, 4, 6, 4, 5, 1'b0, 1'b1);
        chk("cfg_err pulse", 64'(bus.cfg_err_o), 64'(1));
        chk("no pend on invalid", 64'(bus.cfg_pend_o), 64'(0));
        cyc(1);
        chk("cfg_err single cycle", 64'(bus.cfg_err_o), 64'(0));

        // Enable dropped on line 1: frame completes, then idle
        wait_fs(200);
        f0 = fcnt;
        cyc(14);
        en = 1'b0;
        cyc(150);
        chk("idle de", 64'(de), 64'(0));
        chk("idle req", 64'(req), 64'(0));
        chk("idle hs inactive (active-low)", 64'(hs), 64'(1));
        chk("idle vs inactive", 64'(vs), 64'(0));
        chk("frame completed after enable drop", 64'(fcnt), 64'(16'(f0 + 16'd1)));
        cyc(10);
        chk("frame_cnt holds in idle", 64'(fcnt), 64'(16'(f0 + 16'd1)));
        en = 1'b1;
        cyc(1);
        chk("re-enable req leads", 64'(req), 64'(1));
        chk("re-enable de not yet", 64'(de), 64'(0));
        cyc(1);
        chk("re-enable fs", 64'(fs), 64'(1));
        chk("re-enable de", 64'(de), 64'(1));
        chk("re-enable x", 64'(x), 64'(0));
        chk("re-enable y", 64'(y), 64'(0));

        // Update coinciding with frame end while another config is pending
        cyc(5);
        set_cfg(6, 10, 7, 8, 2, 4, 2, 3, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_run && (m_p == m_act.h_tot * m_act.v_tot - 1)) found = 1'b1;
            else @(negedge clk);
        end
        chk("frame end located", 64'(found), 64'(1));
        set_cfg(5, 9, 6, 7, 3, 5, 3, 4, 1'b1, 1'b1);
        chk("new config stays pending", 64'(bus.cfg_pend_o), 64'(1));
        wait_fs(50);
        chk("pending through first new frame", 64'(bus.cfg_pend_o), 64'(1));
        fs_gap("old-pending frame length 40", 40);
        chk("pend cleared one frame later", 64'(bus.cfg_pend_o), 64'(0));
        fs_gap("later config frame length 45", 45);

        // Randomized updates and enable toggling
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: rand_cfg(1'b0);
                4, 5:       rand_cfg(1'b1);
                6, 7:       en = ~en;
                default:    ;
            endcase
            cyc(int'($urandom_range(1, 60)));
        end
        en = 1'b1;
        cyc(200);

        // Asynchronous reset mid-line, then default 1080p timing
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset de", 64'(de), 64'(0));
        chk("async reset req", 64'(req), 64'(0));
        chk("async reset hs", 64'(hs), 64'(0));
        chk("async reset vs", 64'(vs), 64'(0));
        chk("async reset frame_cnt", 64'(fcnt), 64'(0));
        chk("async reset x", 64'(x), 64'(0));
        #1 rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (de === 1'b1) found = 1'b1;
        end
        chk("de after reset release", 64'(found), 64'(1));
        chk("fs at first pixel after reset", 64'(fs), 64'(1));
        nde = 0;
        for (int i = 0; i < 2200; i++) begin
            nde += int'(de);
            @(negedge clk);
        end
        chk("1080p de per line", 64'(nde), 64'(1920));
        found   = 1'b0;
        prev_hs = hs;
        for (int i = 0; i < 2300 && !found; i++) begin
            @(negedge clk);
            if (hs && !prev_hs) found = 1'b1;
            prev_hs = hs;
        end
        nde = -1;
        if (found) begin
            for (int i = 1; i <= 2300 && nde < 0; i++) begin
                @(negedge clk);
                if (hs && !prev_hs) nde = i;
                prev_hs = hs;
            end
        end
        chk("1080p line length", 64'(nde), 64'(2200));

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uivtc_prog.md
Name: uivtc_prog

Overview:
- Runtime-programmable video timing controller; successor to the fixed-parameter VTC.
- Generates HS/VS/DE and an early pixel-fetch request (REQ) with configurable lead.
- Reports pixel coordinates, a frame-start pulse and a frame count.
- Sits between the frame-buffer read path (driven by REQ) and the video output PHY (driven by HS/VS/DE); resolution changes take effect only on frame boundaries.

Parameters:
- CNT_W, 12: width of all timing counters and config fields.
- REQ_LEAD, 1: cycles by which vtc_req_o precedes vtc_de_o; range 0..4.
- DEF_H_ACT/DEF_H_TOT/DEF_HS_START/DEF_HS_END, 1920/2200/2008/2052: horizontal timing loaded at reset.
- DEF_V_ACT/DEF_V_TOT/DEF_VS_START/DEF_VS_END, 1080/1125/1084/1089: vertical timing loaded at reset.
- DEF_HS_POL/DEF_VS_POL, 1/1: sync polarity loaded at reset; 1 = active-high.

Ports:
- vtc_clk_i  in  1  pixel clock.
- vtc_rstn_i  in  1  reset, asynchronous assert, active-low.
- vtc_en_i  in  1  run enable; level-sensitive.
- cfg_h_act_i, cfg_h_tot_i, cfg_hs_start_i, cfg_hs_end_i  in  CNT_W each  new horizontal timing.
- cfg_v_act_i, cfg_v_tot_i, cfg_vs_start_i, cfg_vs_end_i  in  CNT_W each  new vertical timing.
- cfg_hs_pol_i, cfg_vs_pol_i  in  1 each  new sync polarity.
- cfg_upd_i  in  1  single-cycle pulse; samples all cfg_* inputs.
- cfg_err_o  out  1  single-cycle pulse; the sampled config was rejected.
- cfg_pend_o  out  1  a validated config is waiting for the frame boundary.
- vtc_hs_o, vtc_vs_o, vtc_de_o  out  1 each  video syncs and data enable.
- vtc_req_o  out  1  pixel request, REQ_LEAD cycles ahead of DE.
- vtc_x_o, vtc_y_o  out  CNT_W each  coordinates, aligned with vtc_de_o.
- vtc_fs_o  out  1  frame-start pulse, aligned with pixel (0,0) on vtc_de_o.
- vtc_frame_cnt_o  out  16  completed-frame counter.

Behaviour:
- **Reset (asynchronous)**
  - State goes to IDLE; counters go to 0; active and pending config go to the DEF_* values.
  - de, req, fs, cfg_err, cfg_pend, x, y and frame_cnt go to 0.
  - hs_o = ~DEF_HS_POL and vs_o = ~DEF_VS_POL, i.e. the inactive sync levels.
- **States: IDLE, RUN.**
  - IDLE -> RUN on the first cycle vtc_en_i = 1; hcnt and vcnt start at 0 on that cycle.
  - RUN -> IDLE at the end of the frame (hcnt = h_tot-1 and vcnt = v_tot-1) when vtc_en_i = 0. Deasserting enable mid-frame always finishes the current frame.
  - In IDLE: counters hold at 0, de/req/fs = 0, syncs sit at their inactive levels.
- **Counters**
  - hcnt runs 0..h_tot-1 and wraps.
  - vcnt increments when hcnt = h_tot-1 and wraps after v_tot-1.
  - frame_cnt increments at each frame end and wraps at 16 bits.
- **Raw timing (from hcnt/vcnt)**
  - de_raw = (hcnt < h_act) and (vcnt < v_act).
  - hs_raw = hs_start <= hcnt < hs_end.
  - vs_raw = vs_start <= vcnt < vs_end.
- **Output alignment**
  - vtc_req_o = de_raw, registered once (1-cycle latency).
  - hs, vs, de, x, y and fs pass through 1+REQ_LEAD register stages, so req leads de by exactly REQ_LEAD cycles.
  - Sync outputs are XORed with the inverse of the active polarity.
  - x = hcnt and y = vcnt when de is high; both are 0 otherwise.
  - With REQ_LEAD = 0, req is identical to de.
- **Config update**
  - cfg_upd_i samples the inputs and validates them.
  - The config is valid iff 0 < h_act < hs_start < hs_end <= h_tot, 0 < v_act <= vs_start < vs_end <= v_tot, and h_tot >= 4.
  - Invalid config: cfg_err_o pulses 1 cycle later; the pending and active configs are unchanged.
  - Valid config: it overwrites the pending register (a later valid update replaces an earlier one) and cfg_pend_o goes to 1.
  - The pending config transfers to the active config at the frame end, or immediately if in IDLE; cfg_pend_o clears on that cycle.
  - If cfg_upd_i coincides with the frame-end cycle, the previous pending config (if any) is applied and the new one stays pending for the next frame.
- **Frame boundary**: the active config never changes mid-frame; polarity changes also wait for the frame boundary.
- **Widths**: all counter comparisons are unsigned at CNT_W bits; no counter ever exceeds tot-1.

Test Plan:
- Small timing: h 8/12/9/10, v 4/6/4/5, REQ_LEAD = 1, enable held high.
  - req_o high for 8 cycles of each 12 on lines 0-3.
  - de_o is the same pattern 1 cycle later.
  - hs high for 1 cycle at hcnt = 9; vs high for 12 cycles on line 4.
  - fs pulses every 72 cycles; frame_cnt increments by 1 per frame.
- cfg_hs_pol = 0 update mid-frame -> no hs change until the next frame; afterwards hs is low only during hcnt = 9.
- Invalid config h_act = 12, h_tot = 12 -> cfg_err_o 1-cycle pulse, cfg_pend_o = 0, timing unchanged.
- vtc_en_i dropped at line 1 -> the frame completes through vcnt = 5; then IDLE with de = 0 and syncs inactive; re-enable -> (x,y) = (0,0) with fs aligned.
- vtc_rstn_i pulsed low mid-line -> outputs inactive immediately (asynchronously); after release, DEF_* 1080p timing: 2200-cycle lines, 1125-line frames.
- cfg_upd_i on the frame-end cycle with a config already pending -> the old config is applied, the new one stays pending (cfg_pend_o = 1) and is applied one frame later.
